// File: rtl/vector_recorder.sv
// Test-vector capture buffer: records sample words during RECORD, then streams
// them out in capture order over a valid/ready port during DRAIN.
//
// state  | meaning
// IDLE   | waiting for arm; buffer contents retained but not valid for readout
// RECORD | writing sample_data on each sample_valid until stop or full
// DONE   | capture finished; waiting for drain (readout) or arm (restart)
// DRAIN  | streaming mem[0..count-1] out, one beat per accepted handshake
module vector_recorder #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 45,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             stop,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample_data,
   input  logic             drain,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RECORD, DONE, DRAIN} state_t;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [CW-1:0]    rd_ptr_inc;
   logic             write_en;
   logic             accept;

   assign write_en   = (state == RECORD) && sample_valid && !full;
   assign accept     = (state == DRAIN) && rd_valid && rd_ready;
   assign rd_ptr_inc = rd_ptr + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (arm) state_nxt = RECORD;
         RECORD: if (stop || (sample_valid && (full || count == DEPTH_C - CW'(1))))
                    state_nxt = DONE;
         DONE:   if (arm)        state_nxt = RECORD;
                 else if (drain) state_nxt = DRAIN;
         DRAIN:  if (!rd_valid || (rd_ready && rd_last)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      full = (count == DEPTH_C);
   end

   // Storage has no reset so it survives reset and IDLE untouched.
   always_ff @(posedge clk) begin
      if (write_en) mem[wr_ptr] <= sample_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  count    <= '0;
                  wr_ptr   <= '0;
                  overflow <= 1'b0;
               end
            end
            RECORD: begin
               if (sample_valid) begin
                  if (!full) begin
                     wr_ptr <= wr_ptr + CW'(1);
                     count  <= count + CW'(1);
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (arm) begin
                  count    <= '0;
                  wr_ptr   <= '0;
                  overflow <= 1'b0;
               end else begin
                  // A sample arriving after the buffer filled is still a lost sample.
                  if (sample_valid && full) overflow <= 1'b1;
                  if (drain) begin
                     rd_ptr   <= '0;
                     rd_data  <= mem[0];
                     rd_valid <= (count != '0);
                     rd_last  <= (count == CW'(1));
                  end
               end
            end
            DRAIN: begin
               if (accept) begin
                  if (rd_last) begin
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                  end else begin
                     rd_ptr   <= rd_ptr_inc;
                     rd_data  <= mem[rd_ptr_inc];
                     rd_valid <= 1'b1;
                     rd_last  <= (rd_ptr_inc + CW'(1) == count);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_recorder.sv
// Directed and randomized bench for vector_recorder; captured words are tracked
// in a queue and every drained beat is compared against it.
module tb_vector_recorder;

   localparam int WIDTH = 5;
   localparam int DEPTH = 45;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam int M_IDLE = 0;
   localparam int M_REC  = 1;
   localparam int M_DONE = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             arm;
   logic             stop;
   logic             sample_valid;
   logic [WIDTH-1:0] sample_data;
   logic             drain;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic             rd_last;
   logic [CW-1:0]    count;
   logic             full;
   logic             overflow;
   logic             busy;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   logic [WIDTH-1:0] q[$];
   int               m_mode = M_IDLE;
   bit               m_ovf  = 1'b0;

   vector_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop),
      .sample_valid(sample_valid), .sample_data(sample_data), .drain(drain),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_last(rd_last), .count(count), .full(full), .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_count"}, 32'(count), 32'(q.size()));
      chk({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, "_busy"}, 32'(busy), 32'(m_mode != M_IDLE));
      chk({tag, "_rdv"}, 32'(rd_valid), 32'h0);
   endtask

   // One clock of capture-side stimulus, followed by a model update and status check.
   task automatic cyc(input bit sv, input logic [WIDTH-1:0] d, input bit st,
                      input bit ar, input bit dr, input string tag);
      sample_valid = sv; sample_data = d; stop = st; arm = ar; drain = dr;
      step();
      sample_valid = 1'b0; stop = 1'b0; arm = 1'b0; drain = 1'b0;
      case (m_mode)
         M_IDLE: if (ar) begin q.delete(); m_ovf = 1'b0; m_mode = M_REC; end
         M_REC: begin
            if (sv) begin
               if (q.size() < DEPTH) q.push_back(d);
               else m_ovf = 1'b1;
            end
            if (st || q.size() == DEPTH) m_mode = M_DONE;
         end
         M_DONE: begin
            if (ar) begin q.delete(); m_ovf = 1'b0; m_mode = M_REC; end
            else if (sv && q.size() == DEPTH) m_ovf = 1'b1;
         end
         default: ;
      endcase
      check_status(tag);
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1 repeating, 2: random ready
   task automatic drain_all(input int mode, input string tag);
      int n;
      int acc;
      int cycles;
      bit rdy;
      logic [5:0] pat;
      pat = 6'b101001;
      n = q.size();
      acc = 0;
      cycles = 0;
      drain = 1'b1;
      step();
      drain = 1'b0;
      if (n == 0) begin
         chk({tag, "_empty_rdv"}, 32'(rd_valid), 32'h0);
         chk({tag, "_empty_busy"}, 32'(busy), 32'h1);
         step();
         chk({tag, "_empty_idle"}, 32'(busy), 32'h0);
         chk({tag, "_empty_rdv2"}, 32'(rd_valid), 32'h0);
      end else begin
         while (acc < n) begin
            if (cycles > 400) begin
               chk({tag, "_timeout_beats"}, 32'(acc), 32'(n));
               break;
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[cycles % 6];
            else                rdy = 1'($urandom_range(0, 1));
            rd_ready = rdy;
            chk({tag, "_rdv"}, 32'(rd_valid), 32'h1);
            chk({tag, "_data"}, 32'(rd_data), 32'(q[acc]));
            chk({tag, "_last"}, 32'(rd_last), 32'(acc == n - 1));
            step();
            if (rdy) acc++;
            cycles++;
            chk({tag, "_busy"}, 32'(busy), 32'(acc < n));
         end
         rd_ready = 1'b0;
         chk({tag, "_end_rdv"}, 32'(rd_valid), 32'h0);
      end
      m_mode = M_IDLE;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      m_mode = M_IDLE;
      check_status(tag);
      chk({tag, "_rd_last"}, 32'(rd_last), 32'h0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
   endtask

   initial begin
      logic [WIDTH-1:0] basic [5];
      int len;
      basic[0] = 5'b10011; basic[1] = 5'b11000; basic[2] = 5'b01101;
      basic[3] = 5'b11111; basic[4] = 5'b00000;
      rst = 1'b0; arm = 1'b0; stop = 1'b0; sample_valid = 1'b0;
      sample_data = '0; drain = 1'b0; rd_ready = 1'b0;

      do_reset("por");

      cyc(0, '0, 1, 0, 1, "idle_ignore");

      cyc(0, '0, 0, 1, 0, "basic_arm");
      for (int i = 0; i < 5; i++) cyc(1, basic[i], 0, 0, 0, "basic_wr");
      cyc(0, '0, 1, 0, 0, "basic_stop");
      chk("basic_count5", 32'(count), 32'd5);
      drain_all(0, "basic_drain");

      cyc(0, '0, 0, 1, 0, "full_arm");
      for (int i = 0; i < 47; i++) begin
         cyc(1, WIDTH'(i % 32), 0, 0, 0, "full_wr");
         if (i == 44) chk("full_at_45", 32'(full), 32'h1);
      end
      chk("full_overflow", 32'(overflow), 32'h1);
      drain_all(2, "full_drain");

      cyc(0, '0, 0, 1, 0, "bp_arm");
      for (int i = 0; i < 3; i++) cyc(1, WIDTH'($urandom), 0, 0, 0, "bp_wr");
      cyc(0, '0, 1, 0, 0, "bp_stop");
      drain_all(1, "bp_drain");

      cyc(0, '0, 0, 1, 0, "sim_arm");
      for (int i = 0; i < 2; i++) cyc(1, WIDTH'($urandom), 0, 0, 0, "sim_wr");
      cyc(1, 5'b10101, 1, 0, 0, "sim_stop_wr");
      chk("sim_count3", 32'(count), 32'd3);
      cyc(0, '0, 0, 0, 0, "sim_hold");
      cyc(0, '0, 0, 1, 1, "sim_arm_drain");
      for (int i = 0; i < 2; i++) cyc(1, WIDTH'($urandom), 0, 0, 0, "sim_wr2");
      cyc(0, '0, 1, 0, 0, "sim_stop2");
      drain_all(2, "sim_drain");

      cyc(0, '0, 0, 1, 0, "empty_arm");
      cyc(0, '0, 1, 0, 0, "empty_stop");
      drain_all(0, "empty_drain");

      cyc(0, '0, 0, 1, 0, "rstrec_arm");
      for (int i = 0; i < 10; i++) cyc(1, WIDTH'($urandom), 0, 0, 0, "rstrec_wr");
      do_reset("rst_mid_record");

      cyc(0, '0, 0, 1, 0, "rstdr_arm");
      for (int i = 0; i < 4; i++) cyc(1, WIDTH'($urandom), 0, 0, 0, "rstdr_wr");
      cyc(0, '0, 1, 0, 0, "rstdr_stop");
      drain = 1'b1;
      step();
      drain = 1'b0;
      chk("rstdr_rdv", 32'(rd_valid), 32'h1);
      do_reset("rst_mid_drain");

      for (int r = 0; r < 6; r++) begin
         cyc(0, '0, 0, 1, 0, "rnd_arm");
         len = $urandom_range(0, 55);
         for (int i = 0; i < len; i++)
            cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), 0, 0, 0, "rnd_wr");
         cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), 1, 0, 0, "rnd_stop");
         drain_all(2, "rnd_drain");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
